pht_port_sched: RTL and testbench

- Schedules a single-port pattern-history-table SRAM (2-bit counters) between the fetch-side prediction read and the retire-side counter update.
- Clears the table after reset with a hardware sweep.
- Buffers retire updates in a small coalescing queue.
- Forwards queued update data to reads of the same index, so predictions never see stale counters.

---
 rtl/pht_port_sched.sv | 165 ++++++++++++++++
 tb/tb_pht_port_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_port_sched.sv
// Port scheduler for a single-port 2-bit-counter PHT SRAM: reset sweep, coalescing
// update queue drained in idle slots, and read forwarding from pending updates.
module pht_port_sched #(
    parameter int          IDX_W    = 14,
    parameter int          QDEPTH   = 4,
    parameter logic [1:0]  INIT_VAL = 2'b00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_gnt,
    output logic             rd_valid,
    output logic [1:0]       rd_data,
    input  logic             wr_req,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_data,
    output logic             wr_full,
    output logic             init_busy,
    output logic             sram_en,
    output logic             sram_we,
    output logic [IDX_W-1:0] sram_addr,
    output logic [1:0]       sram_wdata,
    input  logic [1:0]       sram_rdata
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       data;
    } upd_t;

    logic [0:0]       state;
    logic [IDX_W-1:0] init_ctr;
    upd_t             q_mem [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             run;
    logic             q_full;
    logic             q_empty;
    logic             drain;
    logic             push;
    logic             wr_hit;
    logic [PTR_W-1:0] wr_pos;
    logic             rd_hit;
    logic [1:0]       rd_fwd;

    logic             rd_valid_q;
    logic             fwd_hit_q;
    logic [1:0]       fwd_data_q;
    logic [1:0]       rd_hold;
    logic [1:0]       rd_now;

    always_comb begin
        run     = (state == ST_RUN);
        q_full  = (count == CNT_W'(QDEPTH));
        q_empty = (count == '0);
        // A full queue takes the port even over a pending read so retire never stalls forever.
        drain   = run && !q_empty && (q_full || !rd_req);
        rd_gnt  = run && !q_full && rd_req;
        push    = wr_req && !q_full;
    end

    // Scan resident entries oldest-first so the last match is the youngest.
    always_comb begin
        wr_hit = 1'b0;
        wr_pos = '0;
        rd_hit = 1'b0;
        rd_fwd = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (CNT_W'(k) < count) begin
                if (q_mem[head + PTR_W'(k)].idx == rd_idx) begin
                    rd_hit = 1'b1;
                    rd_fwd = q_mem[head + PTR_W'(k)].data;
                end
                if ((q_mem[head + PTR_W'(k)].idx == wr_idx) && !(drain && k == 0)) begin
                    wr_hit = 1'b1;
                    wr_pos = head + PTR_W'(k);
                end
            end
        end
    end

    // SRAM port is held idle while reset is asserted, otherwise the sweep would start early.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (rst_n) begin
            if (!run) begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = init_ctr;
                sram_wdata = INIT_VAL;
            end else if (drain) begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = q_mem[head].idx;
                sram_wdata = q_mem[head].data;
            end else if (rd_gnt) begin
                sram_en    = 1'b1;
                sram_addr  = rd_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            init_ctr   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_valid_q <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_hold    <= '0;
        end else begin
            if (!run) begin
                init_ctr <= init_ctr + 1'b1;
                if (init_ctr == {IDX_W{1'b1}})
                    state <= ST_RUN;
            end
            if (push && !wr_hit)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            count      <= count + CNT_W'(push && !wr_hit) - CNT_W'(drain);
            rd_valid_q <= rd_gnt;
            if (rd_gnt) begin
                fwd_hit_q  <= rd_hit;
                fwd_data_q <= rd_fwd;
            end
            if (rd_valid_q)
                rd_hold <= rd_now;
        end
    end

    // Queue storage needs no reset; residency is defined by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            if (wr_hit)
                q_mem[wr_pos].data <= wr_data;
            else
                q_mem[tail] <= '{idx: wr_idx, data: wr_data};
        end
    end

    always_comb begin
        rd_now    = fwd_hit_q ? fwd_data_q : sram_rdata;
        rd_data   = rd_valid_q ? rd_now : rd_hold;
        rd_valid  = rd_valid_q;
        wr_full   = q_full;
        init_busy = !run;
    end

endmodule

// File: tb/tb_pht_port_sched.sv
// Bench for pht_port_sched: directed scenarios plus random traffic, read results
// scored against an architectural table of latest accepted counter values.
module tb_pht_port_sched;

    localparam int         IDX_W = 4;
    localparam int         N     = 16;
    localparam logic [1:0] IV    = 2'b01;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rd_req;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_gnt;
    logic             rd_valid;
    logic [1:0]       rd_data;
    logic             wr_req;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_data;
    logic             wr_full;
    logic             init_busy;
    logic             sram_en;
    logic             sram_we;
    logic [IDX_W-1:0] sram_addr;
    logic [1:0]       sram_wdata;
    logic [1:0]       sram_rdata;

    int checks   = 0;
    int failures = 0;

    logic [1:0] mem  [N];
    logic [1:0] arch [N];
    logic [1:0] expq [$];
    logic       gnt_prev;

    pht_port_sched #(.IDX_W(IDX_W), .QDEPTH(4), .INIT_VAL(IV)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_full(wr_full),
        .init_busy(init_busy),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: architectural model is "latest accepted write per index"; a read granted
    // in a cycle must return the table as it stood before that cycle's writes.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            gnt_prev = 1'b0;
            for (int i = 0; i < N; i++) arch[i] = IV;
        end else begin
            chk("rd_valid_latency", rd_valid, gnt_prev);
            if (rd_valid) begin
                if (expq.size() == 0) chk("rd_unexpected", 1, 0);
                else                  chk("rd_data", rd_data, expq.pop_front());
            end
            if (init_busy) chk("init_no_gnt", rd_gnt, 0);
            else           chk("arb_gnt", rd_gnt, rd_req && !wr_full);
            if (rd_gnt) begin
                chk("rd_sram_access", {sram_en, sram_we, sram_addr}, {1'b1, 1'b0, rd_idx});
                expq.push_back(arch[rd_idx]);
            end
            if (wr_req && !wr_full) arch[wr_idx] = wr_data;
            gnt_prev = rd_gnt;
        end
    end

    task automatic sweep_check();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("sweep_write", {sram_en, sram_we, sram_addr, sram_wdata}, {2'b11, 4'(i), IV});
            chk("sweep_busy", init_busy, 1);
            cyc();
        end
    endtask

    task automatic drain_check(input string name, input int idx, input logic [1:0] d);
        @(negedge clk);
        chk(name, {sram_en, sram_we, sram_addr, sram_wdata}, {2'b11, 4'(idx), d});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        bit done;
        rst_n = 1'b0;
        rd_req = 0; rd_idx = 0; wr_req = 0; wr_idx = 0; wr_data = 0;
        for (int i = 0; i < N; i++) mem[i] = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_busy", init_busy, 1);
        chk("rst_sram", {sram_en, sram_we, sram_addr, sram_wdata}, 0);
        chk("rst_rd", {rd_valid, rd_data, rd_gnt}, 0);
        chk("rst_wr_full", wr_full, 0);

        // 1: sweep with a read held pending
        rd_req = 1; rd_idx = 5;
        rst_n = 1'b1;
        sweep_check();
        @(negedge clk);
        chk("t1_busy_fall", init_busy, 0);
        chk("t1_first_gnt", rd_gnt, 1);
        cyc();
        rd_req = 0;

        // 2: write SRAM[5]=2'b10 via drain, then read it from the SRAM
        wr_req = 1; wr_idx = 5; wr_data = 2'b10;
        cyc();
        wr_req = 0;
        drain_check("t2_drain", 5, 2'b10);
        cyc();
        rd_req = 1; rd_idx = 5;
        @(negedge clk);
        chk("t2_gnt", rd_gnt, 1);
        cyc();
        rd_req = 0;
        @(negedge clk);
        chk("t2_rd", {rd_valid, rd_data}, {1'b1, 2'b10});
        cyc();

        // 3: fill queue under continuous reads; anti-starvation drain
        rd_req = 1; rd_idx = 0;
        for (int j = 1; j <= 4; j++) begin
            wr_req = 1; wr_idx = 4'(j); wr_data = 2'(j);
            @(negedge clk);
            chk("t3_not_full", wr_full, 0);
            cyc();
        end
        wr_req = 0;
        @(negedge clk);
        chk("t3_full", wr_full, 1);
        chk("t3_no_gnt", rd_gnt, 0);
        chk("t3_drain1", {sram_en, sram_we, sram_addr, sram_wdata}, {2'b11, 4'd1, 2'd1});
        cyc();
        @(negedge clk);
        chk("t3_unfull", wr_full, 0);
        chk("t3_gnt_back", rd_gnt, 1);
        cyc();
        rd_req = 0;
        for (int j = 2; j <= 4; j++) begin
            drain_check("t3_drain_order", j, 2'(j));
            cyc();
        end
        @(negedge clk);
        chk("t3_idle", sram_en, 0);
        cyc();

        // 4: coalesce two updates to idx 7
        rd_req = 1; rd_idx = 3; wr_req = 1; wr_idx = 7; wr_data = 2'b11;
        cyc();
        rd_idx = 7; wr_data = 2'b00;
        cyc();
        rd_req = 0; wr_req = 0;
        drain_check("t4_drain", 7, 2'b00);
        cyc();
        @(negedge clk);
        chk("t4_single_drain", sram_en, 0);
        cyc();

        // 5: forwarding from a pending update
        rd_req = 1; rd_idx = 0; wr_req = 1; wr_idx = 9; wr_data = 2'b11;
        cyc();
        wr_req = 0; rd_idx = 9;
        cyc();
        @(negedge clk);
        chk("t5_fwd", {rd_valid, rd_data}, {1'b1, 2'b11});
        chk("t5_sram_stale", mem[9], IV);
        cyc();
        rd_req = 0;
        repeat (3) cyc();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            rd_req  = ($urandom_range(0, 9) < 7);
            rd_idx  = 4'($urandom_range(0, N - 1));
            wr_req  = ($urandom_range(0, 9) < 5);
            wr_idx  = 4'($urandom_range(0, 7));
            wr_data = 2'($urandom);
            cyc();
        end
        rd_req = 0; wr_req = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!sram_en) done = 1;
            cyc();
        end
        chk("rand_drain_done", done, 1);
        for (int i = 0; i < N; i++) chk("rand_sram_final", mem[i], arch[i]);

        // 6: reset mid-sweep with queued updates
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        wr_req = 1; wr_idx = 10; wr_data = 2'b11;
        cyc();
        wr_idx = 11;
        cyc();
        wr_req = 0;
        repeat (4) cyc();
        chk("t6_pre_addr", sram_addr, 6);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sram", {sram_en, sram_we, sram_addr, sram_wdata}, 0);
        chk("t6_rst_flags", {init_busy, wr_full, rd_valid}, 3'b100);
        cyc();
        rst_n = 1'b1;
        sweep_check();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_stale_drain", sram_en, 0);
            cyc();
        end
        chk("t6_mem10", mem[10], IV);
        chk("t6_mem11", mem[11], IV);
        rd_req = 1; rd_idx = 10;
        cyc();
        rd_req = 0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
